// File: rtl/intpol2_iq_fifo.sv
// Dual-channel I/Q synchronous FIFO between the quadratic interpolator core
// and the stream/DMA read side. I and Q share one storage word and one pair
// of pointers, so the two channels can never slip against each other.
module intpol2_iq_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_I_i,
    input  logic [DATA_WIDTH-1:0] data_Q_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_I_o,
    output logic [DATA_WIDTH-1:0] data_Q_o,
    output logic                  Empty_o,
    output logic                  Full_o,
    output logic                  Afull_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Storage word: Q in the high half, I in the low half.
    logic [2*DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_i;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_afull;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_wr_store;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Status decoded only from the registered count, so flags move with count_o.
    assign w_empty = (r_count == {(ADDR_WIDTH+1){1'b0}});
    assign w_full  = (r_count == DEPTH_C);
    assign w_afull = (r_count >= AFULL_C);

    // A read frees a slot in the same cycle, so a write at full still lands.
    assign w_rd_acc   = rd_en_i & ~w_empty;
    assign w_wr_acc   = wr_en_i & (~w_full | w_rd_acc);
    assign w_wr_store = w_wr_acc & ~clear;

    // Occupancy change: +1 on write only, -1 on read only, else unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array write; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (w_wr_store) begin
            r_mem[r_wr_ptr] <= {data_Q_i, data_I_i};
        end
    end

    // Pointers, count, sticky error flags and registered read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr <= {ADDR_WIDTH{1'b0}};
            r_count  <= {(ADDR_WIDTH+1){1'b0}};
            r_data_i <= {DATA_WIDTH{1'b0}};
            r_data_q <= {DATA_WIDTH{1'b0}};
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (clear) begin
            // Flush wins over any request; read data deliberately holds.
            r_wr_ptr <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr <= {ADDR_WIDTH{1'b0}};
            r_count  <= {(ADDR_WIDTH+1){1'b0}};
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_data_i <= r_mem[r_rd_ptr][DATA_WIDTH-1:0];
                r_data_q <= r_mem[r_rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
            end
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | (wr_en_i & ~w_wr_acc);
            r_udf   <= r_udf | (rd_en_i & ~w_rd_acc);
        end
    end

    assign data_I_o = r_data_i;
    assign data_Q_o = r_data_q;
    assign Empty_o  = w_empty;
    assign Full_o   = w_full;
    assign Afull_o  = w_afull;
    assign count_o  = r_count;
    assign ovf_o    = r_ovf;
    assign udf_o    = r_udf;

endmodule

// File: tb/tb_intpol2_iq_fifo.sv
// Scoreboard bench for intpol2_iq_fifo: the driver runs directed vectors and a
// queue model; reads the model accepts push expected words, and a separate
// monitor pops and compares the registered read data one edge later.
module tb_intpol2_iq_fifo;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int THR = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clear = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [DW-1:0] data_I_i = '0;
    logic [DW-1:0] data_Q_i = '0;
    logic          rd_en_i = 1'b0;
    logic [DW-1:0] data_I_o;
    logic [DW-1:0] data_Q_o;
    logic          Empty_o, Full_o, Afull_o, ovf_o, udf_o;
    logic [AW:0]   count_o;

    intpol2_iq_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .wr_en_i(wr_en_i), .data_I_i(data_I_i), .data_Q_i(data_Q_i),
        .rd_en_i(rd_en_i), .data_I_o(data_I_o), .data_Q_o(data_Q_o),
        .Empty_o(Empty_o), .Full_o(Full_o), .Afull_o(Afull_o),
        .count_o(count_o), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [2*DW-1:0] mq[$];      // model FIFO contents {Q,I}
    logic [2*DW-1:0] exp_q[$];   // scoreboard: expected read words
    logic            m_ovf = 1'b0;
    logic            m_udf = 1'b0;
    logic            m_rd_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus model update and status check.
    task automatic step(input logic rst_v, input logic wr, input logic [DW-1:0] di,
                        input logic [DW-1:0] dq, input logic rd, input logic clr);
        logic racc, wacc;
        int   cnt;
        @(negedge clk);
        rstn = rst_v; wr_en_i = wr; data_I_i = di; data_Q_i = dq; rd_en_i = rd; clear = clr;
        racc = 1'b0;
        if (!rst_v || clr) begin
            mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            racc = rd && (mq.size() > 0);
            wacc = wr && ((mq.size() < DEPTH) || racc);
            if (racc) exp_q.push_back(mq.pop_front());
            if (wacc) mq.push_back({dq, di});
            if (wr && !wacc) m_ovf = 1'b1;
            if (rd && !racc) m_udf = 1'b1;
        end
        m_rd_acc = racc;
        @(posedge clk);
        #1;
        cnt = mq.size();
        chk("count", 64'(count_o), 64'(cnt));
        chk("flags{E,F,A,O,U}", 64'({Empty_o, Full_o, Afull_o, ovf_o, udf_o}),
            64'({cnt == 0, cnt == DEPTH, cnt >= THR, m_ovf, m_udf}));
    endtask

    // Monitor: pops one expected word per accepted read, checks data holds otherwise.
    logic [2*DW-1:0] last_exp = '0;
    logic            mon_fire;
    always @(posedge clk) begin
        mon_fire = m_rd_acc;
        #1;
        if (!rstn) begin
            last_exp = '0;
        end else if (mon_fire) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rd_scoreboard: read with no expected word at %0t", $time);
            end else begin
                last_exp = exp_q.pop_front();
            end
        end
        n_checks++;
        if ({data_Q_o, data_I_o} !== last_exp) begin
            n_errors++;
            $display("FAIL rd_data: got %h expected %h at %0t", {data_Q_o, data_I_o}, last_exp, $time);
        end
    end

    int peak;

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
        chk("rst_data_I", 64'(data_I_o), 64'h0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("first_I", 64'(data_I_o), 64'h11111111);
        chk("first_Q", 64'(data_Q_o), 64'h22222222);

        // Fill / drain with overflow and underflow
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b1, 32'(k), ~32'(k), 1'b0, 1'b0);
            if (k == 10) chk("afull_11th", 64'(Afull_o), 64'h0);
            if (k == 11) chk("afull_12th", 64'(Afull_o), 64'h1);
        end
        step(1'b1, 1'b1, 32'hDEAD0000, 32'hBEEF0000, 1'b0, 1'b0);
        chk("full_ovf", 64'({Full_o, ovf_o}), 64'h3);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("udf_hold", 64'({udf_o, Empty_o, data_I_o}), {30'h0, 2'b11, 32'd15});

        // Wrap stress: reads lag writes by 3 cycles
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        peak = 0;
        for (int c = 0; c < 43; c++) begin
            step(1'b1, c < 40, 32'(c), ~32'(c), c >= 3, 1'b0);
            if (int'(count_o) > peak) peak = int'(count_o);
        end
        chk("wrap_peak", 64'(peak), 64'd3);
        chk("wrap_last_I", 64'(data_I_o), 64'd39);

        // Full + simultaneous read/write
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 32'(k), ~32'(k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 32'(100 + k), 32'(200 + k), 1'b1, 1'b0);
        chk("fullsim", 64'({count_o, ovf_o}), {58'h0, 5'd16, 1'b0});
        chk("fullsim_I", 64'(data_I_o), 64'd4);

        // Empty + simultaneous read/write
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'hAAAA5555, 32'h5555AAAA, 1'b1, 1'b0);
        chk("emptysim", 64'({count_o, udf_o, data_I_o}), {26'h0, 5'd1, 1'b1, 32'd4});

        // clear during traffic at count 9
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 32'(50 + k), 32'(60 + k), 1'b0, 1'b0);
        chk("pre_clear_cnt", 64'(count_o), 64'd9);
        step(1'b1, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b1);
        chk("clear", 64'({count_o, Empty_o, ovf_o, udf_o, data_I_o}),
            {26'h0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd4});
        // After flush the pointers restart cleanly
        step(1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("post_clear_Q", 64'(data_Q_o), 64'h9ABCDEF0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
